// File: rtl/arb4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb4_pkg;

    localparam int unsigned CntW = 8;

    typedef logic [1:0] idx_t;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request at or after 'start', wrapping mod 4.
module rr_pick4
    import arb4_pkg::*;
(
    input  logic [3:0] req,
    input  idx_t       start,
    output logic       hit,
    output idx_t       idx,
    output logic [3:0] onehot
);

    idx_t w_pos;

    always_comb begin
        hit   = 1'b0;
        idx   = start;
        w_pos = start;
        // Walk from farthest to nearest so the nearest set bit wins.
        for (int k = 3; k >= 0; k--) begin
            w_pos = start + idx_t'(k);
            if (req[w_pos]) begin
                hit = 1'b1;
                idx = w_pos;
            end
        end
        onehot = hit ? (4'b0001 << idx) : 4'b0000;
    end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with DONE/REQ release and optional hold timeout.
module arb4_rr
    import arb4_pkg::*;
#(
    parameter bit          LOCK = 1'b1,
    parameter int unsigned TMO  = 0
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       CE,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [3:0] GNT,
    output logic [1:0] GNTID,
    output logic       VALID,
    output logic       ANY
);

    localparam logic [CntW-1:0] TmoLim = CntW'((TMO == 0) ? 0 : TMO - 1);

    state_e            r_state, w_state_d;
    idx_t              r_last, w_last_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic [3:0]        r_gnt, w_gnt_d;
    idx_t              r_id, w_id_d;
    logic              r_any;

    logic              w_hit;
    idx_t              w_idx;
    logic [3:0]        w_onehot;
    logic              w_rel;

    rr_pick4 u_pick (
        .req    (REQ),
        .start  (r_last + 2'd1),
        .hit    (w_hit),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    assign w_rel = (LOCK && DONE) || (!LOCK && !REQ[r_id]) ||
                   ((TMO != 0) && (r_cnt == TmoLim));

    always_comb begin
        w_state_d = r_state;
        w_last_d  = r_last;
        w_cnt_d   = r_cnt;
        w_gnt_d   = r_gnt;
        w_id_d    = r_id;
        if (r_state == StIdle || w_rel) begin
            if (w_hit) begin
                w_state_d = StHold;
                w_last_d  = w_idx;
                w_cnt_d   = '0;
                w_gnt_d   = w_onehot;
                w_id_d    = w_idx;
            end else begin
                w_state_d = StIdle;
                w_gnt_d   = 4'b0000;
            end
        end else if (r_cnt != '1) begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= StIdle;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_gnt   <= 4'b0000;
            r_id    <= 2'd0;
            r_any   <= 1'b0;
        end else if (CE) begin
            r_state <= w_state_d;
            r_last  <= w_last_d;
            r_cnt   <= w_cnt_d;
            r_gnt   <= w_gnt_d;
            r_id    <= w_id_d;
            r_any   <= |REQ;
        end
    end

    assign GNT   = r_gnt;
    assign GNTID = r_id;
    assign VALID = |r_gnt;
    assign ANY   = r_any;

endmodule

// File: tb/tb_arb4_rr.sv
// Bench for arb4_rr: three parameterisations driven in parallel against a queued reference model.
module tb_arb4_rr;

    logic       CK;
    logic       RN;
    logic       CE;
    logic [3:0] REQ;
    logic       DONE;

    logic [3:0] gnt [3];
    logic [1:0] gid [3];
    logic       vld [3];
    logic       anyo [3];

    int n_checks = 0;
    int n_fail   = 0;

    arb4_rr #(.LOCK(1'b1), .TMO(0)) u_dut0 (
        .CK(CK), .RN(RN), .CE(CE), .REQ(REQ), .DONE(DONE),
        .GNT(gnt[0]), .GNTID(gid[0]), .VALID(vld[0]), .ANY(anyo[0])
    );
    arb4_rr #(.LOCK(1'b0), .TMO(0)) u_dut1 (
        .CK(CK), .RN(RN), .CE(CE), .REQ(REQ), .DONE(DONE),
        .GNT(gnt[1]), .GNTID(gid[1]), .VALID(vld[1]), .ANY(anyo[1])
    );
    arb4_rr #(.LOCK(1'b1), .TMO(3)) u_dut2 (
        .CK(CK), .RN(RN), .CE(CE), .REQ(REQ), .DONE(DONE),
        .GNT(gnt[2]), .GNTID(gid[2]), .VALID(vld[2]), .ANY(anyo[2])
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct {
        int         inst;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       any;
    } exp_t;

    exp_t sb [$];

    // Reference model state, one slot per instance.
    bit         m_hold [3];
    logic [1:0] m_last [3];
    int         m_cnt  [3];
    logic [3:0] m_gnt  [3];
    logic [1:0] m_id   [3];
    logic       m_any  [3];

    function automatic bit lock_of(input int i);
        return i != 1;
    endfunction

    function automatic int tmo_of(input int i);
        return (i == 2) ? 3 : 0;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pick(input logic [3:0] req, input logic [1:0] last,
                        output bit hit, output logic [1:0] idx);
        int j;
        hit = 1'b0;
        idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            j = (int'(last) + k) % 4;
            if (!hit && req[j]) begin
                hit = 1'b1;
                idx = 2'(j);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hold[i] = 1'b0;
            m_last[i] = 2'd3;
            m_cnt[i]  = 0;
            m_gnt[i]  = 4'b0000;
            m_id[i]   = 2'd0;
            m_any[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        bit         hit;
        bit         rel;
        logic [1:0] idx;
        exp_t       e;
        for (int i = 0; i < 3; i++) begin
            if (!RN) begin
                m_hold[i] = 1'b0;
                m_last[i] = 2'd3;
                m_cnt[i]  = 0;
                m_gnt[i]  = 4'b0000;
                m_id[i]   = 2'd0;
                m_any[i]  = 1'b0;
            end else if (CE) begin
                rel = !m_hold[i] ||
                      (lock_of(i) && DONE) ||
                      (!lock_of(i) && !REQ[m_id[i]]) ||
                      (tmo_of(i) != 0 && m_cnt[i] == tmo_of(i) - 1);
                if (rel) begin
                    pick(REQ, m_last[i], hit, idx);
                    if (hit) begin
                        m_hold[i] = 1'b1;
                        m_last[i] = idx;
                        m_id[i]   = idx;
                        m_gnt[i]  = 4'b0001 << idx;
                        m_cnt[i]  = 0;
                    end else begin
                        m_hold[i] = 1'b0;
                        m_gnt[i]  = 4'b0000;
                    end
                end else if (m_cnt[i] < 255) begin
                    m_cnt[i]++;
                end
                m_any[i] = |REQ;
            end
            e.inst = i;
            e.gnt  = m_gnt[i];
            e.id   = m_id[i];
            e.vld  = |m_gnt[i];
            e.any  = m_any[i];
            sb.push_back(e);
        end
    endtask

    task automatic compare_all();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_value($sformatf("gnt%0d", e.inst), 32'(gnt[e.inst]), 32'(e.gnt));
            check_value($sformatf("valid%0d", e.inst), 32'(vld[e.inst]), 32'(e.vld));
            check_value($sformatf("any%0d", e.inst), 32'(anyo[e.inst]), 32'(e.any));
            if (e.vld) begin
                check_value($sformatf("gntid%0d", e.inst), 32'(gid[e.inst]), 32'(e.id));
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge CK);
        #1;
        compare_all();
    endtask

    initial begin
        RN   = 1'b0;
        CE   = 1'b1;
        REQ  = 4'b0000;
        DONE = 1'b0;
        model_reset();
        repeat (2) step();
        RN = 1'b1;
        step();

        // First grant from reset: scan begins at requester 0.
        REQ = 4'b1010;
        step();
        check_value("first_gnt", 32'(gnt[0]), 32'h2);
        check_value("first_id", 32'(gid[0]), 32'h1);
        check_value("first_any", 32'(anyo[0]), 32'h1);

        // Rotation with periodic DONE.
        REQ = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            DONE = (c % 2 == 1);
            step();
        end
        DONE = 1'b0;

        // REQ-level release.
        REQ = 4'b0101;
        repeat (3) step();
        REQ = 4'b0100;
        repeat (2) step();
        REQ = 4'b0000;
        DONE = 1'b1;
        repeat (2) step();
        DONE = 1'b0;

        // Long hold with DONE absent exercises the timeout instance.
        REQ = 4'b0011;
        repeat (12) step();

        // Clock enable frozen while REQ wiggles.
        CE = 1'b0;
        for (int c = 0; c < 4; c++) begin
            REQ = 4'(c + 5);
            DONE = c[0];
            step();
        end
        CE = 1'b1;
        DONE = 1'b0;
        REQ = 4'b1001;
        repeat (4) step();

        // Randomised traffic.
        for (int c = 0; c < 300; c++) begin
            REQ  = 4'($urandom_range(0, 15));
            DONE = ($urandom_range(0, 3) == 0);
            CE   = ($urandom_range(0, 7) != 0);
            step();
        end
        CE = 1'b1;

        // Drain to idle, then grant requester 2 and reset between edges.
        REQ  = 4'b0000;
        DONE = 1'b1;
        repeat (4) step();
        DONE = 1'b0;
        REQ  = 4'b0100;
        step();
        check_value("pre_rst_gnt", 32'(gnt[0]), 32'h4);
        #2;
        RN = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_value($sformatf("arst_gnt%0d", i), 32'(gnt[i]), 32'h0);
            check_value($sformatf("arst_valid%0d", i), 32'(vld[i]), 32'h0);
            check_value($sformatf("arst_id%0d", i), 32'(gid[i]), 32'h0);
            check_value($sformatf("arst_any%0d", i), 32'(anyo[i]), 32'h0);
        end
        model_reset();
        step();
        #3;
        RN = 1'b1;
        step();
        check_value("post_rst_gnt", 32'(gnt[0]), 32'h4);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb4_rr.md
# arb4_rr

Four-requester round-robin arbiter cell for the ECP2 behavioural simulation library. It is the grant-side counterpart of the OR4 request-merge primitive: it takes the same four request lines that OR4 collapses into one "any request" signal and returns a one-hot grant to exactly one requester. A hold-time limit prevents any one requester from monopolising the grant. It sits between multiple bus masters and a single shared resource in simulation models of arbitrated fabrics.

## Interface

- `LOCK`, default 1: 1 = grant held until `DONE`; 0 = grant held while the grantee's `REQ` stays high.
- `TMO`, default 0: maximum cycles a grant is held, 1..255; 0 disables the timeout.
- `CK`, input, 1 bit: clock, rising edge. One clock; all state is in this domain.
- `RN`, input, 1 bit: reset, asynchronous, active-low.
- `CE`, input, 1 bit: clock enable. When low, all state is frozen.
- `REQ`, input, 4 bits: request lines; bit i = requester i.
- `DONE`, input, 1 bit: release strobe from the current grantee. Used only when `LOCK`=1.
- `GNT`, output, 4 bits: one-hot registered grant, or all-zero.
- `GNTID`, output, 2 bits: binary index of the granted requester. Valid when `VALID`=1.
- `VALID`, output, 1 bit: a grant is active; equals OR-reduction of `GNT`.
- `ANY`, output, 1 bit: registered OR of `REQ`, one cycle late.

## Operation

- **States:** IDLE, HOLD.
- **Pointer `last`** (2 bits): index of the most recent grantee.
- **Pick function:** scans `REQ` starting at `last+1` and wrapping mod 4 through `last` itself. It returns the first set bit.
- **IDLE:**
  - If `REQ`≠0, load `GNT`/`GNTID` from the pick, set `last`, clear the hold counter, and go to HOLD.
  - Otherwise stay in IDLE with `GNT`=0.
- **HOLD, release condition:** (`LOCK`=1 and `DONE`) or (`LOCK`=0 and !`REQ[GNTID]`) or (`TMO`≠0 and counter = `TMO`-1).
- **HOLD, on release:**
  - If the pick over the current `REQ` is non-empty, grant it directly next cycle (back-to-back, no dead cycle) and stay in HOLD.
  - Otherwise go to IDLE with `GNT`=0.
- **Releasing requester:** it is eligible again only after all others, because the scan starts at `last+1`. If it is the sole requester it is re-granted.
- **Hold counter:** 8 bits, counts cycles in the current grant, saturates at 255, and clears on every new grant.
- **Ignored inputs:** `DONE` in IDLE; `DONE` when `LOCK`=0.
- **`CE`=0:** no state, counter or output changes. `ANY` also holds.
- **Asynchronous `RN` low:** forces reset values immediately, mid-grant included. After release, the first grant follows normal IDLE rules.

## Timing

- **Reset values:** `GNT`=0000, `GNTID`=00, `VALID`=0, `ANY`=0, state IDLE, `last`=3 (so the first scan starts at requester 0), counter 0.
- **Request-to-grant latency:** 1 cycle. `REQ` sampled at edge n appears on `GNT` after edge n.
- **Release-to-next-grant:** the release condition sampled at edge n switches `GNT` to the next grantee, or to 0, after edge n.
- **Timeout:** with `TMO`=k a grant is visible for exactly k cycles.
- **Simultaneous `DONE` and timeout:** treated as a single release; pointer and pick are unchanged.
- **All outputs are registered;** no combinational path from inputs to outputs.

## Structure

- **Package `arb4_pkg`:**
  - state enum (IDLE, HOLD);
  - 2-bit index type;
  - localparam for counter width (8).
- **Sub-module `rr_pick4`:** purely combinational. Takes (`req[3:0]`, `start[1:0]`) and returns (`hit`, `idx[1:0]`, `onehot[3:0]`). It is instantiated once and shared by the IDLE and HOLD release paths.

## Test plan

- **Reset and first grant:** `RN` low, then high; `REQ`=1010 → `GNT`=0010, `GNTID`=1 one cycle later. `ANY`=1 one cycle after `REQ`.
- **Rotation:** `LOCK`=1, `REQ`=1111, `DONE` pulsed every 2 cycles → grant order 0,1,2,3,0, with no dead cycles.
- **Release without `DONE`:** `LOCK`=0, `REQ`=0101 granted 0, then `REQ[0]` dropped → `GNT`=0100 next cycle. When `REQ` becomes 0000 → `GNT`=0000, `VALID`=0.
- **Timeout:** `TMO`=3, `REQ`=0011, `DONE` never asserted → grant 0 for 3 cycles, then grant 1 for 3 cycles, then grant 0.
- **Clock enable:** `CE`=0 for 4 cycles while `REQ` changes → `GNT`, `GNTID` and counter unchanged. After `CE`=1, arbitration resumes from the held state.
- **Reset mid-grant:** `RN` asserted between clock edges while `GNT`=0100 → all outputs 0 immediately. After release with `REQ`=0100 → `GNT`=0100 (scan restarts at 0).
